fusion_cf_mc: RTL

Multi-channel, parametrised complementary-filter fusion engine that generalises the single-pair fusion datapath. It accepts a time-multiplexed stream of per-channel samples, each an accelerometer-derived angle plus a gyro rate. For each channel it keeps a filtered-angle state and applies `out = α·(state + gyro·dt) + (1−α)·accel`. It sits between the sensor-sample front end and the downstream consumer, and adds valid/ready handshaking with backpressure and a same-channel hazard interlock.

---
 rtl/fusion_cf_mc.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fusion_cf_mc.sv
// Multi-channel complementary-filter fusion engine.
// Three-stage pipeline (operands, products, sum/saturate) with per-channel
// filter state, valid/ready backpressure and a same-channel hazard interlock.
module fusion_cf_mc #(
  parameter int unsigned W        = 16,
  parameter int unsigned NCH      = 4,
  parameter int unsigned AW       = 8,
  parameter int unsigned DT_SHIFT = 6,
  localparam int unsigned CHW     = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [CHW-1:0]        s_ch,
  input  logic signed [W-1:0]   s_accel,
  input  logic signed [W-1:0]   s_gyro,
  input  logic [AW-1:0]         alpha,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CHW-1:0]        m_ch,
  output logic signed [W-1:0]   m_angle,
  output logic                  m_sat
);

  // Product/sum width: holds alpha*pred + (2^AW-alpha)*accel without overflow.
  localparam int unsigned PW = W + AW + 2;

  localparam logic signed [W-1:0]  MAX_W  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  MIN_W  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [PW-1:0] MAX_PW = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_PW = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

  // Per-channel filter state
  logic signed [W-1:0] state_q [NCH];
  logic signed [W-1:0] state_d [NCH];
  logic [NCH-1:0]      primed_q, primed_d;

  // S1: accepted sample plus state snapshot
  logic                s1_vld_q, s1_vld_d;
  logic [CHW-1:0]      s1_ch_q, s1_ch_d;
  logic signed [W-1:0] s1_accel_q, s1_accel_d;
  logic signed [W-1:0] s1_gyro_q, s1_gyro_d;
  logic [AW-1:0]       s1_alpha_q, s1_alpha_d;
  logic signed [W-1:0] s1_state_q, s1_state_d;
  logic                s1_primed_q, s1_primed_d;

  // S2: blend products
  logic                 s2_vld_q, s2_vld_d;
  logic [CHW-1:0]       s2_ch_q, s2_ch_d;
  logic                 s2_primed_q, s2_primed_d;
  logic signed [W-1:0]  s2_accel_q, s2_accel_d;
  logic signed [PW-1:0] s2_pa_q, s2_pa_d;
  logic signed [PW-1:0] s2_pb_q, s2_pb_d;

  // S3: output register
  logic                m_valid_q, m_valid_d;
  logic [CHW-1:0]      m_ch_q, m_ch_d;
  logic signed [W-1:0] m_angle_q, m_angle_d;
  logic                m_sat_q, m_sat_d;

  // Handshake / datapath intermediates
  logic                 adv_c, hazard_c, accept_c, drop_c;
  logic signed [W-1:0]  rd_state_c;
  logic                 rd_primed_c;
  logic signed [W-1:0]  gyro_dt_c;
  logic signed [W:0]    pred_c;
  logic [AW:0]          wb_c;
  logic signed [PW-1:0] pred_x_c, alpha_x_c, wb_x_c, accel_x_c;
  logic signed [PW-1:0] sum_c, res_c;
  logic signed [W-1:0]  out_angle_c;
  logic                 out_sat_c;

  // Stall, hazard interlock and accept qualification
  always_comb begin
    adv_c    = !m_valid_q || m_ready;
    hazard_c = s_valid && ((s1_vld_q && (s1_ch_q == s_ch)) ||
                           (s2_vld_q && (s2_ch_q == s_ch)));
    s_ready  = adv_c && !hazard_c;
    accept_c = s_valid && s_ready;
    drop_c   = ({1'b0, s_ch} >= (CHW+1)'(NCH));
  end

  // Read the addressed channel's state at accept time
  always_comb begin
    rd_state_c  = '0;
    rd_primed_c = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (CHW'(i) == s_ch) begin
        rd_state_c  = state_q[i];
        rd_primed_c = primed_q[i];
      end
    end
  end

  // S1 load: out-of-range channels are accepted but never enter the pipe
  always_comb begin
    s1_vld_d    = s1_vld_q;
    s1_ch_d     = s1_ch_q;
    s1_accel_d  = s1_accel_q;
    s1_gyro_d   = s1_gyro_q;
    s1_alpha_d  = s1_alpha_q;
    s1_state_d  = s1_state_q;
    s1_primed_d = s1_primed_q;
    if (adv_c) begin
      s1_vld_d = accept_c && !drop_c;
      if (accept_c) begin
        s1_ch_d     = s_ch;
        s1_accel_d  = s_accel;
        s1_gyro_d   = s_gyro;
        s1_alpha_d  = alpha;
        s1_state_d  = rd_state_c;
        s1_primed_d = rd_primed_c;
      end
    end
  end

  // Prediction and blend products from the S1 operands
  always_comb begin
    gyro_dt_c = s1_gyro_q >>> DT_SHIFT;
    pred_c    = {s1_state_q[W-1], s1_state_q} + {gyro_dt_c[W-1], gyro_dt_c};
    wb_c      = (AW+1)'(2**AW) - {1'b0, s1_alpha_q};
    pred_x_c  = {{(PW-W-1){pred_c[W]}}, pred_c};
    alpha_x_c = {{(PW-AW){1'b0}}, s1_alpha_q};
    wb_x_c    = {{(PW-AW-1){1'b0}}, wb_c};
    accel_x_c = {{(PW-W){s1_accel_q[W-1]}}, s1_accel_q};
  end

  // S2 load
  always_comb begin
    s2_vld_d    = s2_vld_q;
    s2_ch_d     = s2_ch_q;
    s2_primed_d = s2_primed_q;
    s2_accel_d  = s2_accel_q;
    s2_pa_d     = s2_pa_q;
    s2_pb_d     = s2_pb_q;
    if (adv_c) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_ch_d     = s1_ch_q;
        s2_primed_d = s1_primed_q;
        s2_accel_d  = s1_accel_q;
        s2_pa_d     = pred_x_c * alpha_x_c;
        s2_pb_d     = wb_x_c * accel_x_c;
      end
    end
  end

  // Sum, floor shift and saturate; unprimed channels pass accel through
  always_comb begin
    sum_c       = s2_pa_q + s2_pb_q;
    res_c       = sum_c >>> AW;
    out_angle_c = s2_accel_q;
    out_sat_c   = 1'b0;
    if (s2_primed_q) begin
      if (res_c > MAX_PW) begin
        out_angle_c = MAX_W;
        out_sat_c   = 1'b1;
      end else if (res_c < MIN_PW) begin
        out_angle_c = MIN_W;
        out_sat_c   = 1'b1;
      end else begin
        out_angle_c = res_c[W-1:0];
      end
    end
  end

  // Output register load
  always_comb begin
    m_valid_d = m_valid_q;
    m_ch_d    = m_ch_q;
    m_angle_d = m_angle_q;
    m_sat_d   = m_sat_q;
    if (adv_c) begin
      m_valid_d = s2_vld_q;
      if (s2_vld_q) begin
        m_ch_d    = s2_ch_q;
        m_angle_d = out_angle_c;
        m_sat_d   = out_sat_c;
      end
    end
  end

  // State write-back on the edge that loads the output register
  always_comb begin
    state_d  = state_q;
    primed_d = primed_q;
    if (adv_c && s2_vld_q) begin
      for (int i = 0; i < NCH; i++) begin
        if (CHW'(i) == s2_ch_q) begin
          state_d[i]  = out_angle_c;
          primed_d[i] = 1'b1;
        end
      end
    end
  end

  // All registers, asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) state_q[i] <= '0;
      primed_q    <= '0;
      s1_vld_q    <= 1'b0;
      s1_ch_q     <= '0;
      s1_accel_q  <= '0;
      s1_gyro_q   <= '0;
      s1_alpha_q  <= '0;
      s1_state_q  <= '0;
      s1_primed_q <= 1'b0;
      s2_vld_q    <= 1'b0;
      s2_ch_q     <= '0;
      s2_primed_q <= 1'b0;
      s2_accel_q  <= '0;
      s2_pa_q     <= '0;
      s2_pb_q     <= '0;
      m_valid_q   <= 1'b0;
      m_ch_q      <= '0;
      m_angle_q   <= '0;
      m_sat_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      primed_q    <= primed_d;
      s1_vld_q    <= s1_vld_d;
      s1_ch_q     <= s1_ch_d;
      s1_accel_q  <= s1_accel_d;
      s1_gyro_q   <= s1_gyro_d;
      s1_alpha_q  <= s1_alpha_d;
      s1_state_q  <= s1_state_d;
      s1_primed_q <= s1_primed_d;
      s2_vld_q    <= s2_vld_d;
      s2_ch_q     <= s2_ch_d;
      s2_primed_q <= s2_primed_d;
      s2_accel_q  <= s2_accel_d;
      s2_pa_q     <= s2_pa_d;
      s2_pb_q     <= s2_pb_d;
      m_valid_q   <= m_valid_d;
      m_ch_q      <= m_ch_d;
      m_angle_q   <= m_angle_d;
      m_sat_q     <= m_sat_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_ch    = m_ch_q;
  assign m_angle = m_angle_q;
  assign m_sat   = m_sat_q;

endmodule
